// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared widths, FSM state type and one-hot helper for the bin controller
package sat_pkg;

    localparam int NUM_CLAUSES      = 8;
    localparam int NUM_VARS         = 8;
    localparam int NUM_LVLS         = 8;
    localparam int WIDTH_LVL        = 16;
    localparam int WIDTH_VAR_STATES = 19;
    localparam int WIDTH_LVL_STATES = 16;

    localparam int WIDTH_CLAUSE = 2 * NUM_VARS;
    localparam int WIDTH_VS_BUS = WIDTH_VAR_STATES * NUM_VARS;
    localparam int WIDTH_LS_BUS = WIDTH_LVL_STATES * NUM_LVLS;
    localparam int WIDTH_IDX    = $clog2(NUM_CLAUSES);

    localparam logic [WIDTH_IDX-1:0] LAST_IDX = WIDTH_IDX'(NUM_CLAUSES - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_CL,
        ST_LD_VS,
        ST_LD_LS,
        ST_START,
        ST_WAIT,
        ST_RD_CL,
        ST_WB,
        ST_FIN
    } bin_ctrl_state_t;

    // Clause index -> clause-array slot strobe.
    function automatic logic [NUM_CLAUSES-1:0] idx_onehot(input logic [WIDTH_IDX-1:0] idx);
        logic [NUM_CLAUSES-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/sat_engine_bin_ctrl.sv
// rtl/sat_engine_bin_ctrl.sv - loads one bin into sat_engine, runs it and streams the clause array back
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start_i + bin inputs      bin request; bin/level numbers and state vectors captured at start_i
//   cl_valid_i/cl_ready_o/cl_data_i   clause load stream (one clause per handshake)
//   wb_valid_o/wb_ready_i/wb_data_o   clause write-back stream
//   busy_o, done_o            activity flag and one-cycle completion pulse
//   sat_o, unsat_o, bkt_lvl_o result of the last bin, held until the next start_i
//   core_*                    direct connection to the sat_engine load/start/readback ports
module sat_engine_bin_ctrl
    import sat_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [WIDTH_LVL-1:0]        bin_num_i,
    input  logic [WIDTH_LVL-1:0]        load_lvl_i,
    input  logic [WIDTH_LVL-1:0]        base_lvl_i,
    input  logic [WIDTH_VS_BUS-1:0]     vars_states_i,
    input  logic [WIDTH_LS_BUS-1:0]     lvl_states_i,
    input  logic                        cl_valid_i,
    output logic                        cl_ready_o,
    input  logic [WIDTH_CLAUSE-1:0]     cl_data_i,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i,
    output logic [WIDTH_CLAUSE-1:0]     wb_data_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        sat_o,
    output logic                        unsat_o,
    output logic [WIDTH_LVL-1:0]        bkt_lvl_o,
    output logic [NUM_CLAUSES-1:0]      core_wr_carray_o,
    output logic [WIDTH_CLAUSE-1:0]     core_clause_o,
    output logic [NUM_VARS-1:0]         core_wr_var_states_o,
    output logic [WIDTH_VS_BUS-1:0]     core_vars_states_o,
    output logic [NUM_LVLS-1:0]         core_wr_lvl_states_o,
    output logic [WIDTH_LS_BUS-1:0]     core_lvl_states_o,
    output logic                        core_start_o,
    output logic [WIDTH_LVL-1:0]        core_cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]        core_load_lvl_o,
    output logic                        core_base_lvl_en_o,
    output logic [WIDTH_LVL-1:0]        core_base_lvl_o,
    output logic [NUM_CLAUSES-1:0]      core_rd_carray_o,
    input  logic                        core_done_i,
    input  logic                        core_sat_i,
    input  logic                        core_unsat_i,
    input  logic [WIDTH_LVL-1:0]        core_bkt_lvl_i,
    input  logic [WIDTH_CLAUSE-1:0]     core_clause_i
);

    bin_ctrl_state_t            state_q, state_d;
    logic [WIDTH_IDX-1:0]       idx_q, idx_d;
    logic [WIDTH_LVL-1:0]       bin_q, bin_d, load_q, load_d, base_q, base_d, bkt_q, bkt_d;
    logic [WIDTH_VS_BUS-1:0]    vs_q, vs_d;
    logic [WIDTH_LS_BUS-1:0]    ls_q, ls_d;
    logic [WIDTH_CLAUSE-1:0]    clause_q, clause_d, wb_data_q, wb_data_d;
    logic [NUM_CLAUSES-1:0]     wr_cl_q, wr_cl_d, rd_cl_q, rd_cl_d;
    logic                       wr_vs_q, wr_vs_d, wr_ls_q, wr_ls_d, start_q, start_d;
    logic                       cl_ready_q, cl_ready_d, wb_valid_q, wb_valid_d;
    logic                       busy_q, busy_d, done_q, done_d, sat_q, sat_d, unsat_q, unsat_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bin_d     = bin_q;
        load_d    = load_q;
        base_d    = base_q;
        vs_d      = vs_q;
        ls_d      = ls_q;
        clause_d  = clause_q;
        wb_data_d = wb_data_q;
        sat_d     = sat_q;
        unsat_d   = unsat_q;
        bkt_d     = bkt_q;
        wr_cl_d   = '0;
        wr_vs_d   = 1'b0;
        wr_ls_d   = 1'b0;
        start_d   = 1'b0;

        // Write strobes are registered from the state's action, so they appear one
        // cycle later; this keeps the final clause write clear of the var-state write.
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    bin_d   = bin_num_i;
                    load_d  = load_lvl_i;
                    base_d  = base_lvl_i;
                    vs_d    = vars_states_i;
                    ls_d    = lvl_states_i;
                    sat_d   = 1'b0;
                    unsat_d = 1'b0;
                    bkt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_LD_CL;
                end
            end
            ST_LD_CL: begin
                if (cl_valid_i && cl_ready_q) begin
                    wr_cl_d  = idx_onehot(idx_q);
                    clause_d = cl_data_i;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_LD_VS;
                    end else begin
                        idx_d = idx_q + WIDTH_IDX'(1);
                    end
                end
            end
            ST_LD_VS: begin
                wr_vs_d = 1'b1;
                state_d = ST_LD_LS;
            end
            ST_LD_LS: begin
                wr_ls_d = 1'b1;
                state_d = ST_START;
            end
            ST_START: begin
                start_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done_i) begin
                    sat_d   = core_sat_i;
                    unsat_d = core_unsat_i;
                    bkt_d   = core_bkt_lvl_i;
                    idx_d   = '0;
                    state_d = ST_RD_CL;
                end
            end
            ST_RD_CL: begin
                // The read strobe is on the core during this cycle; its data is taken at this edge.
                wb_data_d = core_clause_i;
                state_d   = ST_WB;
            end
            ST_WB: begin
                if (wb_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + WIDTH_IDX'(1);
                        state_d = ST_RD_CL;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // These outputs track the state being entered so they are valid within it.
        cl_ready_d = (state_d == ST_LD_CL);
        rd_cl_d    = (state_d == ST_RD_CL) ? idx_onehot(idx_d) : '0;
        wb_valid_d = (state_d == ST_WB);
        done_d     = (state_d == ST_FIN);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            bin_q      <= '0;
            load_q     <= '0;
            base_q     <= '0;
            vs_q       <= '0;
            ls_q       <= '0;
            clause_q   <= '0;
            wb_data_q  <= '0;
            sat_q      <= 1'b0;
            unsat_q    <= 1'b0;
            bkt_q      <= '0;
            wr_cl_q    <= '0;
            rd_cl_q    <= '0;
            wr_vs_q    <= 1'b0;
            wr_ls_q    <= 1'b0;
            start_q    <= 1'b0;
            cl_ready_q <= 1'b0;
            wb_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bin_q      <= bin_d;
            load_q     <= load_d;
            base_q     <= base_d;
            vs_q       <= vs_d;
            ls_q       <= ls_d;
            clause_q   <= clause_d;
            wb_data_q  <= wb_data_d;
            sat_q      <= sat_d;
            unsat_q    <= unsat_d;
            bkt_q      <= bkt_d;
            wr_cl_q    <= wr_cl_d;
            rd_cl_q    <= rd_cl_d;
            wr_vs_q    <= wr_vs_d;
            wr_ls_q    <= wr_ls_d;
            start_q    <= start_d;
            cl_ready_q <= cl_ready_d;
            wb_valid_q <= wb_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign cl_ready_o           = cl_ready_q;
    assign wb_valid_o           = wb_valid_q;
    assign wb_data_o            = wb_data_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign sat_o                = sat_q;
    assign unsat_o              = unsat_q;
    assign bkt_lvl_o            = bkt_q;
    assign core_wr_carray_o     = wr_cl_q;
    assign core_clause_o        = clause_q;
    assign core_wr_var_states_o = {NUM_VARS{wr_vs_q}};
    assign core_vars_states_o   = vs_q;
    assign core_wr_lvl_states_o = {NUM_LVLS{wr_ls_q}};
    assign core_lvl_states_o    = ls_q;
    assign core_start_o         = start_q;
    assign core_base_lvl_en_o   = start_q;
    assign core_cur_bin_num_o   = bin_q;
    assign core_load_lvl_o      = load_q;
    assign core_base_lvl_o      = base_q;
    assign core_rd_carray_o     = rd_cl_q;

endmodule

// File: tb/tb_sat_engine_bin_ctrl.sv
// tb/tb_sat_engine_bin_ctrl.sv - self-checking bench for sat_engine_bin_ctrl with a behavioural core model
module tb_sat_engine_bin_ctrl;
    import sat_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_i = 0, cl_valid_i = 0, wb_ready_i = 0;
    logic [15:0] bin_num_i = 0, load_lvl_i = 0, base_lvl_i = 0;
    logic [WIDTH_VS_BUS-1:0] vars_states_i = 0;
    logic [WIDTH_LS_BUS-1:0] lvl_states_i = 0;
    logic [15:0] cl_data_i = 0;
    logic cl_ready_o, wb_valid_o, busy_o, done_o, sat_o, unsat_o;
    logic [15:0] wb_data_o, bkt_lvl_o, core_clause_o, core_cur_bin_num_o, core_load_lvl_o, core_base_lvl_o;
    logic [7:0] core_wr_carray_o, core_wr_var_states_o, core_wr_lvl_states_o, core_rd_carray_o;
    logic [WIDTH_VS_BUS-1:0] core_vars_states_o;
    logic [WIDTH_LS_BUS-1:0] core_lvl_states_o;
    logic core_start_o, core_base_lvl_en_o;
    logic core_done_i = 0, core_sat_i = 0, core_unsat_i = 0;
    logic [15:0] core_bkt_lvl_i = 0, core_clause_i;

    sat_engine_bin_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .bin_num_i(bin_num_i), .load_lvl_i(load_lvl_i),
        .base_lvl_i(base_lvl_i), .vars_states_i(vars_states_i), .lvl_states_i(lvl_states_i),
        .cl_valid_i(cl_valid_i), .cl_ready_o(cl_ready_o), .cl_data_i(cl_data_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
        .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o), .bkt_lvl_o(bkt_lvl_o),
        .core_wr_carray_o(core_wr_carray_o), .core_clause_o(core_clause_o),
        .core_wr_var_states_o(core_wr_var_states_o), .core_vars_states_o(core_vars_states_o),
        .core_wr_lvl_states_o(core_wr_lvl_states_o), .core_lvl_states_o(core_lvl_states_o),
        .core_start_o(core_start_o), .core_cur_bin_num_o(core_cur_bin_num_o),
        .core_load_lvl_o(core_load_lvl_o), .core_base_lvl_en_o(core_base_lvl_en_o),
        .core_base_lvl_o(core_base_lvl_o), .core_rd_carray_o(core_rd_carray_o),
        .core_done_i(core_done_i), .core_sat_i(core_sat_i), .core_unsat_i(core_unsat_i),
        .core_bkt_lvl_i(core_bkt_lvl_i), .core_clause_i(core_clause_i)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural sat_engine: clause array, var/lvl state stores, read returns the strobed slot.
    logic [15:0] mem [8];
    logic [WIDTH_VS_BUS-1:0] vs_mem;
    logic [WIDTH_LS_BUS-1:0] ls_mem;
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) if (core_wr_carray_o[i]) mem[i] <= core_clause_o;
        if (|core_wr_var_states_o) vs_mem <= core_vars_states_o;
        if (|core_wr_lvl_states_o) ls_mem <= core_lvl_states_o;
    end
    always_comb begin
        core_clause_i = '0;
        for (int i = 0; i < 8; i++) if (core_rd_carray_o[i]) core_clause_i = mem[i];
    end

    // Source data of the current bin and the event log seen on the core side.
    logic [15:0] src_cl [8];
    logic [15:0] exp_bin, exp_load, exp_base;
    logic [WIDTH_VS_BUS-1:0] vs_in;
    logic [WIDTH_LS_BUS-1:0] ls_in;
    int ev_kind[$], ev_idx[$], ev_cyc[$];
    int cyc = 0;
    int mon_n;

    function automatic int oh_idx(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            cyc <= cyc + 1;
            mon_n = $countones(core_wr_carray_o) + $countones(core_rd_carray_o) + int'(|core_wr_var_states_o)
                  + int'(|core_wr_lvl_states_o) + int'(core_start_o);
            if (mon_n != 0) chk("one_strobe", 160'(mon_n), 160'(1));
            if (|core_wr_carray_o) begin ev_kind.push_back(0); ev_idx.push_back(oh_idx(core_wr_carray_o)); ev_cyc.push_back(cyc); end
            if (|core_wr_var_states_o) begin
                ev_kind.push_back(1); ev_idx.push_back(0); ev_cyc.push_back(cyc);
                chk("vs_mask", core_wr_var_states_o, 8'hff);
            end
            if (|core_wr_lvl_states_o) begin
                ev_kind.push_back(2); ev_idx.push_back(0); ev_cyc.push_back(cyc);
                chk("ls_mask", core_wr_lvl_states_o, 8'hff);
            end
            if (core_start_o) begin
                ev_kind.push_back(3); ev_idx.push_back(0); ev_cyc.push_back(cyc);
                chk("base_en", core_base_lvl_en_o, 1);
                chk("base_lvl", core_base_lvl_o, exp_base);
                chk("start_bin", core_cur_bin_num_o, exp_bin);
                chk("start_load_lvl", core_load_lvl_o, exp_load);
            end
            if (|core_rd_carray_o) begin ev_kind.push_back(4); ev_idx.push_back(oh_idx(core_rd_carray_o)); ev_cyc.push_back(cyc); end
        end
    end

    typedef struct {
        int          mode;          // 0: cl_valid always high, 1: valid every other cycle
        int          stall_beat;
        int          stall_len;
        logic        sat;
        logic        unsat;
        logic [15:0] bkt;
        logic [15:0] base;
        bit          start_in_wait;
        bit          done_in_load;
        bit          abort;         // reset while in write-back
        int          exp_load_cyc;
        logic        exp_sat;
        logic        exp_unsat;
        logic [15:0] exp_bkt;
    } vec_t;

    task automatic chk_idle(input string tag);
        chk({tag, "_flags"}, {busy_o, done_o, sat_o, unsat_o, cl_ready_o, wb_valid_o, core_start_o,
             core_base_lvl_en_o, |core_wr_carray_o, |core_rd_carray_o, |core_wr_var_states_o,
             |core_wr_lvl_states_o}, 0);
        chk({tag, "_bkt"}, bkt_lvl_o, 0);
        chk({tag, "_wb_data"}, wb_data_o, 0);
    endtask

    task automatic run_bin(input vec_t v);
        int lc, k, rc, n, beat, stall;
        int cidx[$], ccyc[$], ridx[$];
        int vs_c, ls_c, st_c;
        for (int j = 0; j < 8; j++) begin
            src_cl[j] = 16'($urandom);
            vs_in[j*19 +: 19] = 19'($urandom);
            ls_in[j*16 +: 16] = 16'($urandom);
        end
        exp_bin = 16'($urandom); exp_load = 16'($urandom); exp_base = v.base;
        ev_kind.delete(); ev_idx.delete(); ev_cyc.delete();
        bin_num_i = exp_bin; load_lvl_i = exp_load; base_lvl_i = v.base;
        vars_states_i = vs_in; lvl_states_i = ls_in; start_i = 1;
        @(posedge clk); @(negedge clk);
        start_i = 0; bin_num_i = 16'($urandom); base_lvl_i = 16'($urandom);
        vars_states_i = '0; lvl_states_i = '0;
        chk("busy_after_start", busy_o, 1);
        chk("result_cleared", {sat_o, unsat_o, bkt_lvl_o}, 0);

        lc = 0; k = 0; rc = 0;
        while (k < 8 && lc < 64) begin
            cl_valid_i  = (v.mode == 0) || (lc % 2 == 1);
            cl_data_i   = cl_valid_i ? src_cl[k] : 16'($urandom);
            core_done_i = v.done_in_load && (lc == 3);
            core_sat_i  = 1; core_unsat_i = 1; core_bkt_lvl_i = 16'hdead;
            if (cl_ready_o) rc++;
            if (cl_valid_i && cl_ready_o) k++;
            @(posedge clk); @(negedge clk); lc++;
        end
        cl_valid_i = 0; core_done_i = 0;
        chk("clauses_accepted", k, 8);
        chk("load_cycles", rc, v.exp_load_cyc);
        chk("ready_dropped", cl_ready_o, 0);
        chk("no_result_from_early_done", {sat_o, unsat_o}, 0);

        n = 0;
        while (!core_start_o && n < 20) begin @(negedge clk); n++; end
        chk("start_seen", core_start_o, 1);
        n = $urandom_range(0, 2);
        for (int w = 0; w <= n; w++) begin
            start_i = v.start_in_wait; bin_num_i = ~exp_bin;
            @(negedge clk);
        end
        start_i = 0;
        chk("wait_holds", {wb_valid_o, |core_rd_carray_o}, 0);
        core_done_i = 1; core_sat_i = v.sat; core_unsat_i = v.unsat; core_bkt_lvl_i = v.bkt;
        @(posedge clk); @(negedge clk);
        core_done_i = 0; core_sat_i = ~v.sat; core_unsat_i = ~v.unsat; core_bkt_lvl_i = ~v.bkt;
        chk("sat_latched", {sat_o, unsat_o, bkt_lvl_o}, {v.exp_sat, v.exp_unsat, v.exp_bkt});

        beat = 0; stall = 0; n = 0;
        while (beat < 8 && n < 100) begin
            if (v.abort && beat == 2 && wb_valid_o) begin
                rst = 1;
                @(posedge clk); @(negedge clk);
                rst = 0;
                chk_idle("rst_in_wb");
                return;
            end
            chk("no_early_done", done_o, 0);
            if (wb_valid_o) begin
                chk("wb_data", wb_data_o, src_cl[beat]);
                if (beat == v.stall_beat && stall < v.stall_len) begin
                    wb_ready_i = 0; stall++;
                end else begin
                    wb_ready_i = 1; beat++;
                end
            end else begin
                wb_ready_i = 1'($urandom_range(0, 1));
            end
            @(posedge clk); @(negedge clk); n++;
        end
        wb_ready_i = 0;
        chk("wb_beats", beat, 8);
        chk("done_pulse", {done_o, busy_o}, 2'b11);
        @(negedge clk);
        chk("done_cleared", {done_o, busy_o, wb_valid_o}, 0);
        for (int h = 0; h < 3; h++) begin
            chk("result_held", {sat_o, unsat_o, bkt_lvl_o}, {v.exp_sat, v.exp_unsat, v.exp_bkt});
            @(negedge clk);
        end
        chk("bin_held", core_cur_bin_num_o, exp_bin);

        vs_c = -1; ls_c = -1; st_c = -1;
        foreach (ev_kind[e]) begin
            case (ev_kind[e])
                0: begin cidx.push_back(ev_idx[e]); ccyc.push_back(ev_cyc[e]); end
                1: vs_c = ev_cyc[e];
                2: ls_c = ev_cyc[e];
                3: st_c = ev_cyc[e];
                default: ridx.push_back(ev_idx[e]);
            endcase
        end
        chk("carray_writes", cidx.size(), 8);
        chk("carray_reads", ridx.size(), 8);
        foreach (cidx[j]) chk("carray_order", cidx[j], j);
        foreach (ridx[j]) chk("read_order", ridx[j], j);
        for (int j = 1; j < ccyc.size(); j++) chk("carray_gap", ccyc[j] - ccyc[j-1], (v.mode == 0) ? 1 : 2);
        if (ccyc.size() == 8) begin
            chk("vs_after_cl", vs_c, ccyc[7] + 1);
            chk("ls_after_vs", ls_c, ccyc[7] + 2);
            chk("start_after_ls", st_c, ccyc[7] + 3);
        end
        for (int j = 0; j < 8; j++) chk("core_array", mem[j], src_cl[j]);
        chk("core_vs", vs_mem, vs_in);
        chk("core_ls", ls_mem, ls_in);
    endtask

    vec_t tbl [6];
    vec_t rv;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 0, 0, 1'b1, 1'b0, 16'd0,  16'd3, 1'b0, 1'b0, 1'b0,  8, 1'b1, 1'b0, 16'd0};
        tbl[1] = '{1, 2, 5, 1'b1, 1'b0, 16'd0,  16'd1, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0, 16'd0};
        tbl[2] = '{0, 0, 0, 1'b0, 1'b1, 16'd2,  16'd4, 1'b0, 1'b0, 1'b0,  8, 1'b0, 1'b1, 16'd2};
        tbl[3] = '{1, 7, 2, 1'b0, 1'b1, 16'd5,  16'd0, 1'b1, 1'b1, 1'b0, 16, 1'b0, 1'b1, 16'd5};
        tbl[4] = '{0, 0, 0, 1'b1, 1'b0, 16'd0,  16'd3, 1'b0, 1'b0, 1'b1,  8, 1'b1, 1'b0, 16'd0};
        tbl[5] = '{0, 3, 1, 1'b1, 1'b0, 16'haa, 16'd7, 1'b0, 1'b0, 1'b0,  8, 1'b1, 1'b0, 16'haa};

        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset_held");
        rst = 0;
        @(negedge clk);
        chk_idle("reset_released");

        for (int t = 0; t < 6; t++) run_bin(tbl[t]);

        for (int r = 0; r < 4; r++) begin
            rv.mode          = $urandom_range(0, 1);
            rv.stall_beat    = $urandom_range(0, 7);
            rv.stall_len     = $urandom_range(0, 4);
            rv.sat           = 1'($urandom_range(0, 1));
            rv.unsat         = ~rv.sat;
            rv.bkt           = 16'($urandom);
            rv.base          = 16'($urandom);
            rv.start_in_wait = 1'($urandom_range(0, 1));
            rv.done_in_load  = 1'($urandom_range(0, 1));
            rv.abort         = 1'b0;
            rv.exp_load_cyc  = (rv.mode == 0) ? 8 : 16;
            rv.exp_sat       = rv.sat;
            rv.exp_unsat     = rv.unsat;
            rv.exp_bkt       = rv.bkt;
            run_bin(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
